// File: rtl/yarvi_pkg.sv
// Shared definitions for the yarvi pipeline register-file stage.
//   NOP           : canonical no-op instruction (addi x0,x0,0)
//   state_t       : register-file stage FSM states
//   insn_rs1/2/3  : source register index extractors
//   insn_rd       : destination register index extractor
//   insn_src      : source index for read port k (0 -> rs1, 1 -> rs2, 2 -> rs3)
package yarvi_pkg;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic logic [4:0] insn_rs1(input logic [31:0] insn);
    return insn[19:15];
  endfunction

  function automatic logic [4:0] insn_rs2(input logic [31:0] insn);
    return insn[24:20];
  endfunction

  function automatic logic [4:0] insn_rs3(input logic [31:0] insn);
    return insn[31:27];
  endfunction

  function automatic logic [4:0] insn_rd(input logic [31:0] insn);
    return insn[11:7];
  endfunction

  function automatic logic [4:0] insn_src(input logic [31:0] insn, input int k);
    case (k)
      0:       return insn_rs1(insn);
      1:       return insn_rs2(insn);
      default: return insn_rs3(insn);
    endcase
  endfunction

endpackage

// File: rtl/yarvi_rf_array.sv
// Register storage: NREAD combinational read ports, one synchronous write port.
//   clock : write clock
//   we    : write enable
//   waddr : write index (indices >= NREGS and index 0 are dropped)
//   wdata : write data
//   raddr : read indices, port k at [k*5 +: 5]
//   rdata : read data, port k at [k*XLEN +: XLEN]; index 0 or out of range reads 0
// The storage has no reset; the stage clears it after reset.
module yarvi_rf_array #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NREAD = 2
) (
  input  logic                    clock,
  input  logic                    we,
  input  logic [4:0]              waddr,
  input  logic [XLEN-1:0]         wdata,
  input  logic [NREAD*5-1:0]      raddr,
  output logic [NREAD*XLEN-1:0]   rdata
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clock) begin
    if (we && waddr != 5'd0 && int'(waddr) < NREGS) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NREAD; k++) begin
      if (raddr[k*5 +: 5] != 5'd0 && int'(raddr[k*5 +: 5]) < NREGS) begin
        rdata[k*XLEN +: XLEN] = regs[raddr[k*5 +: AW]];
      end
    end
  end

endmodule

// File: rtl/yarvi_rf_mp.sv
// Register-file stage between decode and execute.
// Registers the incoming instruction and its source indices; source values
// are read combinationally from the latched indices, so writebacks landing
// on or after the latching edge are visible in the stage output.
// After reset the FSM spends NREGS-1 cycles zeroing x1..x(NREGS-1) (CLEAR),
// then sits in RUN until the next reset.
//   clock, reset_n      : clock, asynchronous active-low reset
//   valid, pc, insn     : incoming instruction
//   insn_wr             : incoming instruction writes rd (scoreboard only)
//   hold                : stall, freezes the stage registers
//   ready               : stage accepts instructions (RUN only)
//   wb_valid/wb_rd/wb_val : writeback port
//   rf_valid/rf_pc/rf_insn: registered instruction
//   rf_rs_val           : source values, port k at [k*XLEN +: XLEN]
//   rf_rs_busy          : per-port pending-write flags
// Handshake: an instruction is taken on a rising edge where ready & ~hold;
// valid only qualifies the taken slot, it is not a request needing ready.
// Optional feature macro: YARVI_RF_SCOREBOARD_EN (pending-write scoreboard).
module yarvi_rf_mp
  import yarvi_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int VLEN  = 64,
  parameter int NREGS = 32,
  parameter int NREAD = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  valid,
  input  logic [VLEN-1:0]       pc,
  input  logic [31:0]           insn,
  input  logic                  insn_wr,
  input  logic                  hold,
  output logic                  ready,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_rd,
  input  logic [XLEN-1:0]       wb_val,
  output logic                  rf_valid,
  output logic [VLEN-1:0]       rf_pc,
  output logic [31:0]           rf_insn,
  output logic [NREAD*XLEN-1:0] rf_rs_val,
  output logic [NREAD-1:0]      rf_rs_busy
);

  state_t state, state_nxt;
  logic [4:0] cnt;
  logic [NREAD*5-1:0] rp;
  logic accept, wb_eff;
  logic arr_we;
  logic [4:0] arr_waddr;
  logic [XLEN-1:0] arr_wdata;

  // FSM state and clear counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      cnt   <= 5'd1;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) cnt <= cnt + 5'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      CLEAR: if (int'(cnt) == NREGS - 1) state_nxt = RUN;
      RUN:   ready = 1'b1;
      default: state_nxt = CLEAR;
    endcase
  end

  assign accept = ready & ~hold;
  assign wb_eff = (state == RUN) && wb_valid && wb_rd != 5'd0 && int'(wb_rd) < NREGS;

  // The single write port is owned by the clear sweep until RUN.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = 5'd0;
    arr_wdata = '0;
    if (state == CLEAR) begin
      arr_we    = 1'b1;
      arr_waddr = cnt;
    end else if (wb_eff) begin
      arr_we    = 1'b1;
      arr_waddr = wb_rd;
      arr_wdata = wb_val;
    end
  end

  // Stage pipeline registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_valid <= 1'b0;
      rf_pc    <= '0;
      rf_insn  <= NOP;
      rp       <= '0;
    end else if (state != RUN) begin
      rf_valid <= 1'b0;
    end else if (accept) begin
      rf_valid <= valid;
      rf_pc    <= pc;
      rf_insn  <= insn;
      for (int k = 0; k < NREAD; k++) begin
        rp[k*5 +: 5] <= insn_src(insn, k);
      end
    end
  end

  yarvi_rf_array #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NREAD (NREAD)
  ) u_array (
    .clock (clock),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (rp),
    .rdata (rf_rs_val)
  );

`ifdef YARVI_RF_SCOREBOARD_EN
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  logic [NREGS-1:0] sb;
  logic [4:0] set_rd;
  assign set_rd = insn_rd(insn);

  // Clear first, then set, so an issue claiming the register being written
  // back on the same edge keeps it busy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sb <= '0;
    end else begin
      if (wb_eff) sb[wb_rd[AW-1:0]] <= 1'b0;
      if (accept && valid && insn_wr && set_rd != 5'd0 && int'(set_rd) < NREGS)
        sb[set_rd[AW-1:0]] <= 1'b1;
    end
  end

  always_comb begin
    rf_rs_busy = '0;
    for (int k = 0; k < NREAD; k++) begin
      if (int'(rp[k*5 +: 5]) < NREGS) rf_rs_busy[k] = sb[rp[k*5 +: AW]];
    end
  end
`else
  logic unused_insn_wr;
  assign unused_insn_wr = insn_wr;
  assign rf_rs_busy = '0;
`endif

endmodule

// File: tb/tb_yarvi_rf_mp.sv
module tb_yarvi_rf_mp;
  localparam int XLEN  = 64;
  localparam int VLEN  = 64;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam logic [31:0] NOP_I = 32'h00000013;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  valid = 1'b0;
  logic [VLEN-1:0]       pc = '0;
  logic [31:0]           insn = NOP_I;
  logic                  insn_wr = 1'b0;
  logic                  hold = 1'b0;
  logic                  ready;
  logic                  wb_valid = 1'b0;
  logic [4:0]            wb_rd = '0;
  logic [XLEN-1:0]       wb_val = '0;
  logic                  rf_valid;
  logic [VLEN-1:0]       rf_pc;
  logic [31:0]           rf_insn;
  logic [NREAD*XLEN-1:0] rf_rs_val;
  logic [NREAD-1:0]      rf_rs_busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  // clock / reset block
  always #5 clock = ~clock;

  yarvi_rf_mp #(.XLEN(XLEN), .VLEN(VLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clock(clock), .reset_n(reset_n), .valid(valid), .pc(pc), .insn(insn),
    .insn_wr(insn_wr), .hold(hold), .ready(ready), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_val(wb_val), .rf_valid(rf_valid), .rf_pc(rf_pc),
    .rf_insn(rf_insn), .rf_rs_val(rf_rs_val), .rf_rs_busy(rf_rs_busy)
  );

  // reference model: architectural state described by the rules directly
  logic [XLEN-1:0] m_regs [NREGS];
  logic [NREGS-1:0] m_sb;
  logic            m_valid;
  logic [VLEN-1:0] m_pc;
  logic [31:0]     m_insn;

  function automatic logic [4:0] src_of(input logic [31:0] i, input int k);
    if (k == 0) return i[19:15];
    if (k == 1) return i[24:20];
    return i[31:27];
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
    m_sb = '0;
    m_valid = 1'b0;
    m_pc = '0;
    m_insn = NOP_I;
  endtask

  task automatic model_edge();
    if (wb_valid && wb_rd != 0) begin
      m_regs[wb_rd] = wb_val;
      m_sb[wb_rd] = 1'b0;
    end
    if (!hold) begin
      m_valid = valid;
      m_pc = pc;
      m_insn = insn;
      if (valid && insn_wr && insn[11:7] != 0) m_sb[insn[11:7]] = 1'b1;
    end
  endtask

  // driver tasks
  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [VLEN-1:0] p, input logic [31:0] i,
                        input logic iw, input logic h, input logic wv,
                        input logic [4:0] wr, input logic [XLEN-1:0] wd);
    valid = v; pc = p; insn = i; insn_wr = iw; hold = h;
    wb_valid = wv; wb_rd = wr; wb_val = wd;
  endtask

  task automatic check_model(input string tag);
    logic [XLEN-1:0] ev;
    logic eb;
    check({tag, ".rf_valid"}, {63'b0, rf_valid}, {63'b0, m_valid});
    check({tag, ".rf_pc"}, rf_pc, m_pc);
    check({tag, ".rf_insn"}, {32'b0, rf_insn}, {32'b0, m_insn});
    for (int k = 0; k < NREAD; k++) begin
      ev = m_regs[src_of(m_insn, k)];
`ifdef YARVI_RF_SCOREBOARD_EN
      eb = m_sb[src_of(m_insn, k)];
`else
      eb = 1'b0;
`endif
      check($sformatf("%s.rs_val%0d", tag, k), rf_rs_val[k*XLEN +: XLEN], ev);
      check($sformatf("%s.rs_busy%0d", tag, k), {63'b0, rf_rs_busy[k]}, {63'b0, eb});
    end
  endtask

  // release reset and count edges until ready; bounded wait
  task automatic wait_clear(input string tag);
    int n;
    set_in(0, '0, NOP_I, 0, 0, 0, '0, '0);
    reset_n = 1'b1;
    n = 0;
    while (n < 200) begin
      @(posedge clock);
      #1;
      n++;
      if (ready) break;
    end
    check({tag, ".clear_cycles"}, 64'(n), 64'(NREGS - 1));
    model_reset();
  endtask

  typedef struct {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic [31:0]     insn;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_val;
    logic            exp_valid;
    logic [VLEN-1:0] exp_pc;
    logic [31:0]     exp_insn;
    logic [XLEN-1:0] exp_rs0;
    logic [XLEN-1:0] exp_rs1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{0, 64'h0,    NOP_I,        1, 5'd5, 64'h1234, 0, 64'h0,    NOP_I,        64'h0,    64'h0};
    vecs[1] = '{0, 64'h0,    NOP_I,        1, 5'd6, 64'hABCD, 0, 64'h0,    NOP_I,        64'h0,    64'h0};
    vecs[2] = '{1, 64'h1000, 32'h006280B3, 0, 5'd0, 64'h0,    1, 64'h1000, 32'h006280B3, 64'h1234, 64'hABCD};
    vecs[3] = '{1, 64'h1004, 32'h00500133, 1, 5'd0, 64'hFF,   1, 64'h1004, 32'h00500133, 64'h0,    64'h1234};
    vecs[4] = '{1, 64'h1008, 32'h00000133, 0, 5'd0, 64'h0,    1, 64'h1008, 32'h00000133, 64'h0,    64'h0};
    vecs[5] = '{1, 64'h100C, 32'h006381B3, 1, 5'd7, 64'h55,   1, 64'h100C, 32'h006381B3, 64'h55,   64'hABCD};

    model_reset();

    // reset values
    repeat (3) @(posedge clock);
    #1;
    check("rst.ready", {63'b0, ready}, 64'h0);
    check("rst.rf_valid", {63'b0, rf_valid}, 64'h0);
    check("rst.rf_pc", rf_pc, 64'h0);
    check("rst.rf_insn", {32'b0, rf_insn}, {32'b0, NOP_I});
    check("rst.rs_val0", rf_rs_val[0 +: XLEN], 64'h0);
    check("rst.rs_busy", {62'b0, rf_rs_busy}, 64'h0);

    wait_clear("clear1");

    // fill every register with garbage, then reset mid-RUN
    for (int r = 1; r < NREGS; r++) begin
      set_in(0, '0, NOP_I, 0, 0, 1, 5'(r), {$urandom, $urandom} | 64'h1);
      tick();
    end
    set_in(0, '0, NOP_I, 0, 0, 0, '0, '0);
    reset_n = 1'b0;
    #1;
    check("rst_run.ready", {63'b0, ready}, 64'h0);
    check("rst_run.rf_valid", {63'b0, rf_valid}, 64'h0);
    @(negedge clock);
    wait_clear("clear2");

    // every register reads zero after the clear sweep
    for (int r = 0; r < NREGS; r += 2) begin
      set_in(1, 64'(r), {7'b0, 5'(r + 1), 5'(r), 3'b0, 5'b0, 7'h33}, 0, 0, 0, '0, '0);
      tick();
      check($sformatf("zero.x%0d", r), rf_rs_val[0 +: XLEN], 64'h0);
      check($sformatf("zero.x%0d", r + 1), rf_rs_val[XLEN +: XLEN], 64'h0);
    end

    // table-driven directed vectors
    for (int i = 0; i < 6; i++) begin
      set_in(vecs[i].valid, vecs[i].pc, vecs[i].insn, 0, 0,
             vecs[i].wb_valid, vecs[i].wb_rd, vecs[i].wb_val);
      tick();
      check($sformatf("vec%0d.rf_valid", i), {63'b0, rf_valid}, {63'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d.rf_pc", i), rf_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d.rf_insn", i), {32'b0, rf_insn}, {32'b0, vecs[i].exp_insn});
      check($sformatf("vec%0d.rs0", i), rf_rs_val[0 +: XLEN], vecs[i].exp_rs0);
      check($sformatf("vec%0d.rs1", i), rf_rs_val[XLEN +: XLEN], vecs[i].exp_rs1);
    end

    // hold for 3 cycles while x7 is rewritten
    for (int c = 0; c < 3; c++) begin
      set_in(1, 64'hDEAD, 32'hFFFFFFFF, 0, 1, c == 0, 5'd7, 64'h99);
      tick();
      check($sformatf("hold%0d.rf_pc", c), rf_pc, 64'h100C);
      check($sformatf("hold%0d.rf_insn", c), {32'b0, rf_insn}, 64'h006381B3);
      check($sformatf("hold%0d.rs0", c), rf_rs_val[0 +: XLEN], 64'h99);
      check_model($sformatf("hold%0d", c));
    end
    reset_n = 1'b0;
    #1;
    check("hold_rst.rf_valid", {63'b0, rf_valid}, 64'h0);
    check("hold_rst.ready", {63'b0, ready}, 64'h0);
    @(negedge clock);
    wait_clear("clear3");

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      set_in(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom,
             1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, NREGS - 1)),
             {$urandom, $urandom});
      tick();
      check_model($sformatf("rnd%0d", c));
    end

`ifdef YARVI_RF_SCOREBOARD_EN
    // issue writing x3, then a reader of x3
    set_in(1, 64'h2000, 32'h000001B3, 1, 0, 0, '0, '0);
    tick();
    set_in(1, 64'h2004, 32'h00018033, 0, 0, 0, '0, '0);
    tick();
    check("sb.x3_busy", {63'b0, rf_rs_busy[0]}, 64'h1);
    check_model("sb.a");
    // writeback x3 while holding the reader in place
    set_in(0, '0, NOP_I, 0, 1, 1, 5'd3, 64'h33);
    tick();
    check("sb.x3_clear", {63'b0, rf_rs_busy[0]}, 64'h0);
    check_model("sb.b");
    // issue claiming x4 on the same edge as a writeback to x4
    set_in(1, 64'h2008, 32'h00000233, 1, 0, 1, 5'd4, 64'h44);
    tick();
    set_in(1, 64'h200C, 32'h00020033, 0, 0, 0, '0, '0);
    tick();
    check("sb.x4_set_wins", {63'b0, rf_rs_busy[0]}, 64'h1);
    check_model("sb.c");
`else
    set_in(1, 64'h2000, 32'h000001B3, 1, 0, 0, '0, '0);
    tick();
    set_in(1, 64'h2004, 32'h00018033, 0, 0, 0, '0, '0);
    tick();
    check("nosb.busy", {62'b0, rf_rs_busy}, 64'h0);
    check_model("nosb");
`endif

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/yarvi_rf_mp.md
# yarvi_rf_mp

Parametrised multi-port register-file stage for the yarvi pipeline, sitting between fetch/decode and execute. It registers the incoming instruction, latches its source-register indices and presents their values one cycle later, with hold (stall) support. After reset it self-clears the register array before accepting instructions. An optional scoreboard flags source registers that still have a write in flight.

## Interface
- `XLEN`, 64: register width in bits.
- `VLEN`, 64: PC width in bits.
- `NREGS`, 32: architectural registers; power of two, ≤ 32; x0 hardwired to zero.
- `NREAD`, 2: read ports, 2 or 3. Port 2 reads `insn[31:27]` (rs3).
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `valid`  in  1  incoming instruction valid.
- `pc`  in  VLEN  incoming PC.
- `insn`  in  32  incoming instruction.
- `insn_wr`  in  1  incoming instruction writes `insn[11:7]` (rd).
- `hold`  in  1  stall: freeze the rf stage registers.
- `ready`  out  1  stage accepts instructions (high only in RUN).
- `wb_valid`  in  1  writeback strobe.
- `wb_rd`  in  5  writeback index.
- `wb_val`  in  XLEN  writeback data.
- `rf_valid`  out  1  stage output valid.
- `rf_pc`  out  VLEN  registered PC.
- `rf_insn`  out  32  registered instruction.
- `rf_rs_val`  out  NREAD*XLEN  source values, port k at `[k*XLEN +: XLEN]`.
- `rf_rs_busy`  out  NREAD  per-port pending-write flag.

## Operation
- FSM: CLEAR → RUN. Reset forces CLEAR with the index counter at 1.
- CLEAR: write 0 to `regs[cnt]` each cycle and increment `cnt`; at `cnt == NREGS-1`, write it and go to RUN. That is NREGS-1 cycles. `ready` is 0, and `wb_valid` and `valid` are ignored.
- RUN is terminal until reset.
- Accept condition: `ready & ~hold`.
- On accept: `rf_valid <= valid`, `rf_pc <= pc`, `rf_insn <= insn`, and `rp[k] <=` the source field of `insn` for port k.
- With `hold`: all rf stage registers keep their values.
- Outside RUN: `rf_valid <= 0`.
- Write: when in RUN with `wb_valid` and `wb_rd != 0`, `regs[wb_rd] <= wb_val`. Indices ≥ NREGS are ignored.
- Reads are combinational, `rf_rs_val[k] = (rp[k]==0) ? 0 : regs[rp[k]]`. Consequences:
  - A write landing on the same edge that latches `rp` is visible immediately.
  - During a hold, later writes are reflected in the held output.
- x0 reads as 0 always; writes to x0 are dropped.

## Timing
- Reset values:
  - `rf_valid` = 0, `rf_pc` = 0, `rf_insn` = 32'h00000013 (NOP), all `rp` = 0.
  - `ready` = 0, `rf_rs_busy` = 0, scoreboard all 0.
  - Register array contents are undefined until CLEAR completes.
- Latency: input to `rf_*` in 1 cycle. Writeback to a read port: visible in the cycle after the write edge.
- First accept occurs NREGS-1 cycles after `reset_n` rises.
- `reset_n` asserted mid-CLEAR or mid-RUN: asynchronous return to the reset state; CLEAR restarts from 1.
- A simultaneous write and read of the same register returns the new value (see Operation).

## Configuration
- `YARVI_RF_SCOREBOARD_EN` defined:
  - NREGS-bit scoreboard `sb`.
  - Set `sb[rd]` on accept with `valid & insn_wr & rd != 0`.
  - Clear `sb[wb_rd]` on an effective write.
  - Same index set and cleared in one cycle: set wins.
  - `rf_rs_busy[k] = sb[rp[k]]`, combinational like the values.
- Not defined: no scoreboard; `rf_rs_busy` tied to 0 and `insn_wr` unused.

## Structure
- Shared package `yarvi_pkg`:
  - Instruction field extractors rs1 `[19:15]`, rs2 `[24:20]`, rs3 `[31:27]`, rd `[11:7]`.
  - NOP constant 32'h00000013.
  - FSM state enum {CLEAR, RUN}.
- One natural sub-module, `yarvi_rf_array`: storage with NREAD combinational read ports and one write port. The stage module holds the FSM, pipeline registers and scoreboard.

## Test plan
- **Reset clear:** preload the array with garbage via the bench backdoor, release `reset_n`. Expect `ready` to rise exactly NREGS-1 cycles later, and every register to read 0 on all ports.
- **Basic read:** write x5 = 0x1234 and x6 = 0xABCD, then issue `add x1,x5,x6` (`insn` = 0x006280B3). Next cycle expect `rf_rs_val` = {0xABCD, 0x1234}, `rf_valid` = 1, and `rf_pc`/`rf_insn` echo the inputs.
- **x0 rules:** write x0 = 0xFF, then read rs1 = 0. Expect 0.
- **Same-edge write:** `wb x7 = 0x55` on the same edge that accepts an insn reading x7. Expect 0x55 the next cycle.
- **Hold:** assert `hold` for 3 cycles while writing x7 = 0x99. Expect `rf_insn`/`rf_pc` unchanged and `rf_rs_val` showing 0x99 after the write. `reset_n` pulsed mid-hold → `rf_valid` = 0 and `ready` = 0 immediately.
- **Scoreboard (macro on):**
  - Issue with `insn_wr` and rd = x3, then an insn reading x3: expect `rf_rs_busy[0]` = 1.
  - `wb x3`: busy clears next cycle.
  - Simultaneous issue-set and wb-clear of x4: expect `sb[4]` = 1.
